// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving a kernel and a picture requester access to a
// shared 16-bit memory port; each grant fetches three beats and returns them
// as one 48-bit word.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CLK_MEM,
  input  logic              REQ_K,
  input  logic [ADDR_W-1:0] ADDR_K,
  input  logic              REQ_P,
  input  logic [ADDR_W-1:0] ADDR_P,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  input  logic [15:0]       MEM_READ,
  output logic [47:0]       READ,
  output logic              VALID_K,
  output logic              VALID_P,
  output logic [1:0]        GRANT,
  output logic              BUSY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          beat_q, beat_d;
  logic                last_q, last_d;     // 0 = kernel served last, 1 = picture
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [31:0]         shadow_q, shadow_d; // beats 0 and 1 of the word in flight
  logic [47:0]         read_q, read_d;
  logic [1:0]          grant_q, grant_d;
  logic                pick_k;

  // State register and datapath registers, cleared asynchronously.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      last_q   <= 1'b1;
      base_q   <= '0;
      shadow_q <= '0;
      read_q   <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      last_q   <= last_d;
      base_q   <= base_d;
      shadow_q <= shadow_d;
      read_q   <= read_d;
      grant_q  <= grant_d;
    end
  end

  // Next-state logic: arbitration in IDLE, beat sequencing on memory strobes.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    last_d   = last_q;
    base_d   = base_q;
    shadow_d = shadow_q;
    read_d   = read_q;
    grant_d  = grant_q;
    pick_k   = REQ_K && (!REQ_P || last_q);

    case (state_q)
      S_IDLE: begin
        if (CLK_MEM && (REQ_K || REQ_P)) begin
          base_d  = pick_k ? ADDR_K : ADDR_P;
          grant_d = pick_k ? 2'b01 : 2'b10;
          last_d  = !pick_k;
          beat_d  = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (CLK_MEM) state_d = S_DATA;
      end
      S_DATA: begin
        if (CLK_MEM) begin
          case (beat_q)
            2'd0: shadow_d[31:16] = MEM_READ;
            2'd1: shadow_d[15:0]  = MEM_READ;
            default: ;
          endcase
          if (beat_q == 2'd2) begin
            // Last beat goes straight into READ together with the shadow so
            // the full word is already visible while VALID is high in DONE.
            read_d  = {shadow_q, MEM_READ};
            state_d = S_DONE;
          end else begin
            beat_d  = beat_q + 2'd1;
            state_d = S_ADDR;
          end
        end
      end
      S_DONE: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign MEM_ADDRESS = (state_q == S_IDLE) ? '0 : base_q + ADDR_W'(beat_q);
  assign READ        = read_q;
  assign GRANT       = grant_q;
  assign BUSY        = (state_q != S_IDLE);
  assign VALID_K     = (state_q == S_DONE) && grant_q[0];
  assign VALID_P     = (state_q == S_DONE) && grant_q[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic,
// all checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          CLK_MEM;
  logic          REQ_K, REQ_P;
  logic [AW-1:0] ADDR_K, ADDR_P;
  logic [AW-1:0] MEM_ADDRESS;
  logic [15:0]   MEM_READ = '0;
  logic [47:0]   READ;
  logic          VALID_K, VALID_P, BUSY;
  logic [1:0]    GRANT;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(AW)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .CLK_MEM     (CLK_MEM),
    .REQ_K       (REQ_K),
    .ADDR_K      (ADDR_K),
    .REQ_P       (REQ_P),
    .ADDR_P      (ADDR_P),
    .MEM_ADDRESS (MEM_ADDRESS),
    .MEM_READ    (MEM_READ),
    .READ        (READ),
    .VALID_K     (VALID_K),
    .VALID_P     (VALID_P),
    .GRANT       (GRANT),
    .BUSY        (BUSY)
  );

  // Memory contents as a pure function of address.
  function automatic logic [15:0] mem_fn(input logic [AW-1:0] a);
    if (a == 32'h100) return 16'hAAAA;
    if (a == 32'h101) return 16'hBBBB;
    if (a == 32'h102) return 16'hCCCC;
    return (a[15:0] * 16'h9E37) ^ a[31:16] ^ 16'h1234;
  endfunction

  // Memory port: address sampled on a strobe, data returned by the next strobe.
  always @(posedge CLK) if (CLK_MEM) MEM_READ <= mem_fn(MEM_ADDRESS);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a transfer is "strobes seen since grant"; beat i is
  // requested during strobes 2i..2i+1 and its data arrives on strobe 2i+2.
  bit            m_busy, m_done, m_owner, m_last;
  int            m_strobes;
  logic [AW-1:0] m_base;
  logic [47:0]   m_acc, m_read;

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_last = 1; m_owner = 0;
    m_strobes = 0; m_base = '0; m_acc = '0; m_read = '0;
  endtask

  task automatic model_edge();
    if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (!m_busy) begin
      if (CLK_MEM && (REQ_K || REQ_P)) begin
        m_owner   = (REQ_K && REQ_P) ? !m_last : REQ_P;
        m_last    = m_owner;
        m_base    = m_owner ? ADDR_P : ADDR_K;
        m_busy    = 1;
        m_strobes = 0;
      end
    end else if (CLK_MEM) begin
      m_strobes++;
      if (m_strobes % 2 == 0)
        m_acc = {m_acc[31:0], mem_fn(m_base + AW'(m_strobes / 2 - 1))};
      if (m_strobes == 6) begin
        m_done = 1;
        m_read = m_acc;
      end
    end
  endtask

  function automatic logic [AW-1:0] exp_addr();
    if (!m_busy) return '0;
    return m_base + AW'(m_done ? 2 : m_strobes / 2);
  endfunction

  task automatic compare_all();
    check("busy",    64'(BUSY),        64'(m_busy));
    check("grant",   64'(GRANT),       m_busy ? (m_owner ? 64'd2 : 64'd1) : 64'd0);
    check("mem_addr",64'(MEM_ADDRESS), 64'(exp_addr()));
    check("valid_k", 64'(VALID_K),     64'(m_done && !m_owner));
    check("valid_p", 64'(VALID_P),     64'(m_done && m_owner));
    check("read",    64'(READ),        64'(m_read));
  endtask

  // Stimulus bookkeeping.
  int          cyc = 0;
  int          strobe_mode = 0;   // 0 tied high, 1 every 3rd cycle, 2 random
  int          g_cyc = 0;
  int          last_lat = 0;
  int          n_valid = 0;
  logic [1:0]  prev_grant = '0;
  logic [1:0]  grants[$];

  // One CLK period, entered and left at a falling edge.
  task automatic cycle();
    case (strobe_mode)
      0:       CLK_MEM = 1'b1;
      1:       CLK_MEM = (cyc % 3 == 0);
      default: CLK_MEM = ($urandom_range(0, 9) < 6);
    endcase
    #1;
    compare_all();
    if (GRANT != 2'b00 && prev_grant == 2'b00) begin
      g_cyc = cyc;
      grants.push_back(GRANT);
    end
    if (VALID_K || VALID_P) begin
      last_lat = cyc - g_cyc;
      n_valid++;
    end
    prev_grant = GRANT;
    @(posedge CLK);
    if (!RESET) model_edge();
    @(negedge CLK);
    cyc++;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    #1;
    model_reset();
    check("rst_read",  64'(READ), 64'd0);
    check("rst_grant", 64'(GRANT), 64'd0);
    check("rst_addr",  64'(MEM_ADDRESS), 64'd0);
    check("rst_valid", 64'({VALID_K, VALID_P, BUSY}), 64'd0);
    repeat (2) cycle();
    RESET = 1'b0;
  endtask

  task automatic wait_valid(input int max, input string tag);
    int v0 = n_valid;
    int i  = 0;
    while (n_valid == v0 && i < max) begin
      cycle();
      i++;
    end
    check({tag, "_done"}, 64'(n_valid != v0), 64'd1);
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFFF - AW'($urandom_range(0, 2));
    return AW'($urandom);
  endfunction

  int v_before;

  initial begin
    RESET = 1'b1; CLK_MEM = 1'b0;
    REQ_K = 1'b0; REQ_P = 1'b0; ADDR_K = '0; ADDR_P = '0;
    model_reset();
    @(negedge CLK);
    do_reset();

    // Single kernel fetch with the strobe tied high.
    strobe_mode = 0;
    REQ_K = 1'b1; ADDR_K = 32'h100;
    wait_valid(20, "k_basic");
    REQ_K = 1'b0;
    check("k_basic_read", 64'(READ), 64'hAAAA_BBBB_CCCC);
    check("k_basic_lat",  64'(last_lat), 64'd6);
    cycle();

    // Both requesting from reset: grants alternate starting with kernel.
    do_reset();
    grants.delete();
    REQ_K = 1'b1; REQ_P = 1'b1; ADDR_K = 32'h1000; ADDR_P = 32'h2000;
    repeat (4) wait_valid(20, "rr");
    REQ_K = 1'b0; REQ_P = 1'b0;
    cycle();
    check("rr_count", 64'(grants.size()), 64'd4);
    if (grants.size() >= 4) begin
      check("rr_g0", 64'(grants[0]), 64'd1);
      check("rr_g1", 64'(grants[1]), 64'd2);
      check("rr_g2", 64'(grants[2]), 64'd1);
      check("rr_g3", 64'(grants[3]), 64'd2);
    end

    // Strobe every third cycle, picture fetch.
    strobe_mode = 1;
    REQ_P = 1'b1; ADDR_P = 32'h20;
    wait_valid(60, "p_slow");
    REQ_P = 1'b0;
    check("p_slow_lat", 64'(last_lat), 64'd18);
    check("p_slow_read", 64'(READ),
          64'({mem_fn(32'h20), mem_fn(32'h21), mem_fn(32'h22)}));
    strobe_mode = 0;
    cycle();

    // Address wrap at all-ones.
    REQ_K = 1'b1; ADDR_K = 32'hFFFF_FFFF;
    wait_valid(20, "wrap");
    REQ_K = 1'b0;
    check("wrap_read", 64'(READ),
          64'({mem_fn(32'hFFFF_FFFF), mem_fn(32'h0), mem_fn(32'h1)}));
    cycle();

    // Reset during beat 1 of a kernel transfer.
    REQ_K = 1'b1; ADDR_K = 32'h400;
    repeat (4) cycle();
    v_before = n_valid;
    REQ_P = 1'b1; ADDR_P = 32'h500;
    do_reset();
    check("rst_mid_novalid", 64'(n_valid), 64'(v_before));
    grants.delete();
    wait_valid(20, "rst_first");
    REQ_K = 1'b0; REQ_P = 1'b0;
    check("rst_first_grant", grants.size() > 0 ? 64'(grants[0]) : 64'd0, 64'd1);
    cycle();

    // Request dropped and address changed right after grant.
    REQ_K = 1'b1; ADDR_K = 32'h300;
    cycle();
    REQ_K = 1'b0; ADDR_K = 32'h9999;
    wait_valid(20, "drop");
    check("drop_read", 64'(READ),
          64'({mem_fn(32'h300), mem_fn(32'h301), mem_fn(32'h302)}));
    cycle();

    // Randomized traffic.
    strobe_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if (REQ_K) begin
        if ((VALID_K && $urandom_range(0, 1) == 0) || $urandom_range(0, 39) == 0) REQ_K = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        REQ_K = 1'b1; ADDR_K = pick_addr();
      end
      if (REQ_P) begin
        if ((VALID_P && $urandom_range(0, 1) == 0) || $urandom_range(0, 39) == 0) REQ_P = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        REQ_P = 1'b1; ADDR_P = pick_addr();
      end
      if ($urandom_range(0, 7) == 0) ADDR_K = pick_addr();
      if ($urandom_range(0, 7) == 0) ADDR_P = pick_addr();
      if ($urandom_range(0, 399) == 0) do_reset();
      else cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of the requester and memory address ports.
REQ-002 CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 RESET  input  1  reset, asynchronous, active-high.
REQ-004 CLK_MEM  input  1  memory-cycle strobe; FSM advances only on CLK edges where CLK_MEM=1, except in DONE.
REQ-005 REQ_K  input  1  kernel requester wants one 48-bit word; held high until VALID_K.
REQ-006 ADDR_K  input  ADDR_W  kernel base address, in 16-bit beats.
REQ-007 REQ_P  input  1  picture requester wants one 48-bit word; held high until VALID_P.
REQ-008 ADDR_P  input  ADDR_W  picture base address, in 16-bit beats.
REQ-009 MEM_ADDRESS  output  ADDR_W  address driven to the shared 16-bit memory port.
REQ-010 MEM_READ  input  16  memory data; valid at the strobe following the strobe that sampled MEM_ADDRESS.
REQ-011 READ  output  48  assembled word of the last completed transfer.
REQ-012 VALID_K  output  1  one-CLK pulse; READ holds the kernel result.
REQ-013 VALID_P  output  1  one-CLK pulse; READ holds the picture result.
REQ-014 GRANT  output  2  owner of the current transfer: 2'b01 kernel, 2'b10 picture, 2'b00 none.
REQ-015 BUSY  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 States SHALL be IDLE, ADDR, DATA, DONE, with a 2-bit beat counter and a last-served pointer LAST (0 = kernel, 1 = picture).
REQ-017 IDLE: at a strobe edge with REQ_K or REQ_P high, SHALL latch the winner's address into BASE, set GRANT, clear beat to 0 and go to ADDR; with no request it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin:
- A single requester always wins.
- When both request, the one not equal to LAST wins.
- LAST updates to the winner at grant.
REQ-019 ADDR: MEM_ADDRESS SHALL equal BASE+beat, computed modulo 2^ADDR_W (wraps at all-ones); at the next strobe edge go to DATA.
REQ-020 DATA: at the next strobe edge, SHALL capture MEM_READ into a shadow register.
- Beat 0 goes to [47:32], beat 1 to [31:16], beat 2 to [15:0].
- If beat==2, go to DONE; otherwise increment beat and go to ADDR.
REQ-021 DONE: SHALL copy the shadow register to READ and pulse the granted VALID_x high for exactly one CLK cycle, independent of CLK_MEM.
- At the next CLK edge, return to IDLE with GRANT=2'b00.
REQ-022 MEM_ADDRESS SHALL hold BASE+beat through DATA and DONE, and SHALL be 0 in IDLE.
REQ-023 Latency: with CLK_MEM tied high, VALID_x SHALL assert after the 6th CLK edge following the grant edge; in general, after 6 strobe edges.
REQ-024 ADDR_x changes after grant SHALL be ignored until the next grant.
REQ-025 Deasserting REQ_x mid-transfer SHALL NOT abort the transfer; the VALID_x pulse is still issued.
REQ-026 READ SHALL keep its previous value until the DONE of the next transfer; partial beats SHALL never be visible on READ.
REQ-027 A request still high during DONE SHALL NOT be granted before the following IDLE strobe edge.
- Consequence: at least one IDLE cycle between transfers.
REQ-028 VALID_K and VALID_P SHALL never be high simultaneously.

Reset
REQ-029 On RESET=1, asynchronously and regardless of CLK_MEM:
- State=IDLE, beat=0, LAST=1 (kernel wins the first tie).
- BASE=0, shadow=0.
- READ=48'h0, MEM_ADDRESS=0, GRANT=2'b00, VALID_K=VALID_P=0, BUSY=0.
REQ-030 Reset asserted mid-transfer SHALL discard the transfer with no VALID pulse; the first grant after release SHALL follow REQ-018 with the reset LAST.

Verification
REQ-031 CLK_MEM=1, REQ_K=1, ADDR_K=0x100, memory returns 0xAAAA/0xBBBB/0xCCCC for 0x100/0x101/0x102 -> MEM_ADDRESS sequence 0x100,0x101,0x102; READ=48'hAAAA_BBBB_CCCC; VALID_K one cycle, 6 edges after grant.
REQ-032 REQ_K and REQ_P both high from reset, held -> grants alternate K,P,K,P; VALID_K/VALID_P alternate with one IDLE cycle between transfers.
REQ-033 CLK_MEM high every 3rd CLK, REQ_P=1, ADDR_P=0x20 -> FSM advances only on strobe edges; VALID_P after 18 CLK edges; READ correct.
REQ-034 ADDR_K=0xFFFF_FFFF -> MEM_ADDRESS sequence 0xFFFF_FFFF, 0x0000_0000, 0x0000_0001.
REQ-035 RESET pulsed during beat 1 of a kernel transfer -> outputs zero immediately, no VALID_K; after release with both requests high, kernel is granted first.
REQ-036 REQ_K dropped and ADDR_K changed after grant -> transfer completes at the original address; VALID_K pulses.
